// File: rtl/speed_measure_dp.sv
// Speed measurement datapath: ms time base, restoring divider (DIST_CONST / time_ms),
// overspeed flag, barrier control and optional vehicle counter (macro VEH_COUNT_EN).
module speed_measure_dp #(
    parameter int WIDTH_MS    = 14,
    parameter int WIDTH_SPEED = 14,
    parameter int SYS_FREQ    = 10000000,
    parameter int TICK_HZ     = 1000,
    parameter int DIST_CONST  = 14400,
    parameter int SPEED_LIMIT = 1000,
    parameter int WIDTH_VEH   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   init,
    input  logic                   count,
    input  logic                   cal,
    input  logic                   up,
    input  logic                   down,
    input  logic                   en,
    input  logic                   dis,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   done,
    output logic                   busy,
    output logic                   overspeed,
    output logic                   timeout,
    output logic                   en_barrier,
    output logic [WIDTH_VEH-1:0]   num_veh
);

    localparam int DIV = SYS_FREQ / TICK_HZ;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(WIDTH_SPEED + 1);
    localparam logic [WIDTH_SPEED-1:0] DIVIDEND = WIDTH_SPEED'(DIST_CONST);
    localparam logic [WIDTH_SPEED-1:0] LIMIT    = WIDTH_SPEED'(SPEED_LIMIT);

    logic [TW-1:0]          r_tik;
    logic [WIDTH_MS-1:0]    r_time_ms;
    logic                   r_timeout;
    logic [WIDTH_MS-1:0]    r_div;
    logic [WIDTH_MS-1:0]    r_rem;
    logic [WIDTH_SPEED-1:0] r_quot;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_fin;
    logic [WIDTH_SPEED-1:0] r_speed;
    logic                   r_done;
    logic                   r_overspeed;
    logic                   r_en_barrier;

    logic                   w_tik_wrap;
    logic [WIDTH_MS-1:0]    w_ms_inc;
    logic [WIDTH_MS:0]      w_shift;
    logic [WIDTH_MS:0]      w_sub;
    logic                   w_ge;
    logic [WIDTH_MS-1:0]    w_rem_next;

    assign w_tik_wrap = (r_tik == TW'(DIV - 1));
    assign w_ms_inc   = r_time_ms + 1'b1;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign w_shift    = {r_rem, r_quot[WIDTH_SPEED-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_sub      = w_shift - {1'b0, r_div};
    assign w_rem_next = w_ge ? w_sub[WIDTH_MS-1:0] : w_shift[WIDTH_MS-1:0];

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tik     <= '0;
            r_time_ms <= '0;
            r_timeout <= 1'b0;
        end else if (init) begin
            r_tik     <= '0;
            r_time_ms <= '0;
            r_timeout <= 1'b0;
        end else if (count) begin
            if (w_tik_wrap) begin
                r_tik <= '0;
                if (r_time_ms != '1) begin
                    r_time_ms <= w_ms_inc;
                    if (w_ms_inc == '1)
                        r_timeout <= 1'b1;
                end
            end else begin
                r_tik <= r_tik + 1'b1;
            end
        end
    end

    // r_fin marks a finished quotient; it is published on the following edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_fin       <= 1'b0;
            r_speed     <= '0;
            r_done      <= 1'b0;
            r_overspeed <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (init) begin
                r_busy  <= 1'b0;
                r_fin   <= 1'b0;
                r_cnt   <= '0;
                r_speed <= '0;
            end else begin
                if (r_fin) begin
                    r_speed     <= r_quot;
                    r_done      <= 1'b1;
                    r_overspeed <= (r_quot > LIMIT);
                    r_fin       <= 1'b0;
                end
                if (r_busy) begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[WIDTH_SPEED-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_busy <= 1'b0;
                        r_fin  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end else if (cal) begin
                    if (r_time_ms == '0) begin
                        r_quot <= '1;
                        r_fin  <= 1'b1;
                    end else begin
                        r_div  <= r_time_ms;
                        r_rem  <= '0;
                        r_quot <= DIVIDEND;
                        r_cnt  <= CW'(WIDTH_SPEED - 1);
                        r_busy <= 1'b1;
                    end
                end
            end
        end
    end

    // Set wins over clear when both arrive together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_en_barrier <= 1'b0;
        else if (up || en)
            r_en_barrier <= 1'b1;
        else if (dis || down)
            r_en_barrier <= 1'b0;
    end

`ifdef VEH_COUNT_EN
    logic [WIDTH_VEH-1:0] r_num_veh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_num_veh <= '0;
        else if (up && !down && (r_num_veh != '1))
            r_num_veh <= r_num_veh + 1'b1;
        else if (down && !up && (r_num_veh != '0))
            r_num_veh <= r_num_veh - 1'b1;
    end

    assign num_veh = r_num_veh;
`else
    assign num_veh = '0;
`endif

    assign speed      = r_speed;
    assign done       = r_done;
    assign busy       = r_busy;
    assign overspeed  = r_overspeed;
    assign timeout    = r_timeout;
    assign en_barrier = r_en_barrier;

endmodule

// File: tb/tb_speed_measure_dp.sv
// Directed bench for speed_measure_dp with a result scoreboard; a second instance
// with a 4-bit ms counter covers saturation and timeout.
module tb_speed_measure_dp;

    logic        clk = 1'b0;
    logic        reset_n, init, count, cal, up, down, en, dis;
    logic [13:0] speed, speed4;
    logic        done, busy, overspeed, timeout, en_barrier;
    logic        done4, busy4, overspeed4, timeout4, en_barrier4;
    logic [3:0]  num_veh, num_veh4;

    typedef struct {
        int spd;
        int ovs;
    } exp_t;

    exp_t sb[$];
    int   sb4[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    speed_measure_dp #(.SYS_FREQ(10000), .TICK_HZ(1000)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .count(count), .cal(cal),
        .up(up), .down(down), .en(en), .dis(dis),
        .speed(speed), .done(done), .busy(busy), .overspeed(overspeed),
        .timeout(timeout), .en_barrier(en_barrier), .num_veh(num_veh)
    );

    speed_measure_dp #(.WIDTH_MS(4), .SYS_FREQ(10000), .TICK_HZ(1000)) dut4 (
        .clk(clk), .reset_n(reset_n), .init(init), .count(count), .cal(cal),
        .up(up), .down(down), .en(en), .dis(dis),
        .speed(speed4), .done(done4), .busy(busy4), .overspeed(overspeed4),
        .timeout(timeout4), .en_barrier(en_barrier4), .num_veh(num_veh4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic run_count(input int n);
        count = 1'b1;
        repeat (n) tick();
        count = 1'b0;
    endtask

    // Issue cal, then watch 40 cycles: latency, busy length, number of done pulses.
    task automatic run_cal(input string tag, input int exp_spd, input int exp_ovs,
                           input int exp_lat, input int exp_busy, input bit recal,
                           input int exp4);
        int   busy_cnt;
        int   done_cnt;
        exp_t e;
        sb.push_back('{spd: exp_spd, ovs: exp_ovs});
        if (exp4 >= 0) sb4.push_back(exp4);
        cal = 1'b1;
        tick();
        cal = 1'b0;
        busy_cnt = int'(busy);
        done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            cal = recal && (k == 5);
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                check({tag, "_latency"}, k, exp_lat);
                if (sb.size() == 0) begin
                    check({tag, "_unexpected_done"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_speed"}, speed, e.spd);
                    check({tag, "_overspeed"}, overspeed, e.ovs);
                end
            end
            if (done4 && sb4.size() != 0)
                check({tag, "_speed_w4"}, speed4, sb4.pop_front());
        end
        cal = 1'b0;
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_sb_empty"}, sb.size() + sb4.size(), 0);
    endtask

    initial begin
        int done_cnt;
        reset_n = 1'b0;
        {init, count, cal, up, down, en, dis} = '0;
        repeat (3) tick();
        check("rst_speed", speed, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_overspeed", overspeed, 0);
        check("rst_timeout", timeout, 0);
        check("rst_barrier", en_barrier, 0);
        check("rst_num_veh", num_veh, 0);
        reset_n = 1'b1;
        tick();

        // 120 cycles / 10 = 12 ms -> 14400/12
        pulse_init();
        run_count(120);
        run_cal("ms12", 1200, 1, 15, 14, 1'b0, -1);

        // 20 ms on the main unit; the 4-bit unit saturates at 15 ms
        pulse_init();
        run_count(200);
        check("w4_timeout_set", timeout4, 1);
        check("main_timeout_clear", timeout, 0);
        run_cal("ms20_recal", 720, 0, 15, 14, 1'b1, 960);

        pulse_init();
        check("init_speed", speed, 0);
        check("init_w4_timeout", timeout4, 0);
        run_cal("ms0", 16383, 1, 1, 0, 1'b0, 16383);

        up = 1'b1; dis = 1'b1;
        tick();
        check("bar_up_dis", en_barrier, 1);
        up = 1'b0; dis = 1'b0; down = 1'b1;
        tick();
        check("bar_down", en_barrier, 0);
        down = 1'b0; en = 1'b1;
        tick();
        check("bar_en", en_barrier, 1);
        en = 1'b0; dis = 1'b1;
        tick();
        check("bar_dis", en_barrier, 0);
        dis = 1'b0;

`ifdef VEH_COUNT_EN
        up = 1'b1;
        repeat (17) tick();
        check("veh_sat_high", num_veh, 15);
        down = 1'b1;
        tick();
        check("veh_hold", num_veh, 15);
        up = 1'b0;
        repeat (20) tick();
        check("veh_sat_low", num_veh, 0);
        down = 1'b0;
`else
        up = 1'b1;
        repeat (3) tick();
        up = 1'b0;
        check("veh_tied", num_veh, 0);
`endif

        // Reset in the middle of a divide: cleared outputs, no stray done.
        run_count(50);
        cal = 1'b1;
        tick();
        cal = 1'b0;
        repeat (5) tick();
        check("mid_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_speed", speed, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overspeed", overspeed, 0);
        tick();
        reset_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/speed_measure_dp.md
SPEED_MEASURE_DP -- requirements
Module: speed_measure_dp

Interface
REQ-001 The block SHALL have parameter WIDTH_MS, default 14, the width of the millisecond counter.
REQ-002 The block SHALL have parameter WIDTH_SPEED, default 14, the width of speed, dividend and quotient.
REQ-003 The block SHALL have parameter SYS_FREQ, default 10000000, the clk frequency in Hz.
REQ-004 The block SHALL have parameter TICK_HZ, default 1000, the time-base rate in Hz; DIV = SYS_FREQ/TICK_HZ.
REQ-005 The block SHALL have parameter DIST_CONST, default 14400, the dividend; it must fit in WIDTH_SPEED bits.
REQ-006 The block SHALL have parameter SPEED_LIMIT, default 1000, the overspeed threshold.
REQ-007 The block SHALL have parameter WIDTH_VEH, default 4, the width of the vehicle counter.
REQ-008 The block SHALL have these ports:
- clk  in  1  clock, all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- init  in  1  clear the timer and any divide in progress.
- count  in  1  advance the timer.
- cal  in  1  start a speed calculation.
- up, down  in  1 each  vehicle entry and exit events.
- en, dis  in  1 each  barrier force-set and force-clear.
- speed  out  WIDTH_SPEED  last calculated speed.
- done  out  1  one-cycle pulse when speed is updated.
- busy  out  1  divide in progress.
- overspeed  out  1  registered flag, speed > SPEED_LIMIT.
- timeout  out  1  sticky flag, the ms counter saturated.
- en_barrier  out  1  barrier enable.
- num_veh  out  WIDTH_VEH  vehicles currently inside.

Function
REQ-009 The prescaler tik SHALL count 0..DIV-1 only while count=1, then wrap to 0; when it wraps, time_ms SHALL increment.
REQ-010 time_ms SHALL saturate at all-ones and not wrap; on reaching all-ones, timeout SHALL be set and stay set until init.
REQ-011 init SHALL clear tik, time_ms, timeout, busy, done and speed in one cycle, and SHALL override count and cal in the same cycle.
REQ-012 cal while busy=0 and init=0 SHALL capture divisor = time_ms; cal while busy=1 SHALL be ignored.
REQ-013 When divisor is non-zero, the block SHALL compute DIST_CONST/divisor by sequential restoring division, one quotient bit per cycle.
- busy SHALL be high for exactly WIDTH_SPEED cycles.
- speed and done SHALL update WIDTH_SPEED+1 cycles after the cal edge.
REQ-014 When divisor = 0, speed SHALL be all-ones and done SHALL pulse 1 cycle after cal; busy stays low.
REQ-015 speed SHALL hold its value between completions; the remainder is discarded (truncation).
REQ-016 overspeed SHALL update in the same cycle as done, to (new speed > SPEED_LIMIT), and hold otherwise.
REQ-017 The timer SHALL keep running during a divide; the divide uses only the captured divisor.
REQ-018 en_barrier SHALL be set on up|en and cleared on dis|down; set has priority when both occur in the same cycle.

Reset
REQ-019 While reset_n=0, all counters, the divider state and all outputs SHALL be 0, asynchronously.
REQ-020 Reset released mid-divide SHALL leave the block idle, with no done pulse.

Configuration
REQ-021 With macro VEH_COUNT_EN defined, num_veh SHALL behave as follows:
- up alone increments, saturating at all-ones.
- down alone decrements, saturating at 0.
- up and down in the same cycle hold the value.
REQ-022 Without VEH_COUNT_EN, num_veh SHALL be tied to 0 and no counter logic shall be synthesised.

Verification (SYS_FREQ=10000, TICK_HZ=1000 so DIV=10; defaults otherwise)
REQ-023 init, then count high for 120 cycles, then cal -> time_ms=12; done pulses 15 cycles after cal with speed=1200 and overspeed=1.
REQ-024 count for 200 cycles, then cal -> speed=720, overspeed=0; a second cal pulsed while busy -> exactly one done.
REQ-025 init, then cal with time_ms=0 -> done pulses 1 cycle later with speed=16383.
REQ-026 WIDTH_MS=4, count for 200 cycles -> time_ms holds at 15 and timeout=1; init -> both cleared.
REQ-027 up and dis in the same cycle -> en_barrier=1; the next cycle with down only -> en_barrier=0.
REQ-028 With VEH_COUNT_EN:
- 17 up pulses -> num_veh=15.
- up and down together -> num_veh stays 15.
- 20 down pulses -> num_veh=0.
- reset_n asserted mid-divide -> speed=0, done never pulses.
